// File: rtl/simd_sched_pkg.sv
// simd_sched_pkg: shared lane constants, lane/tag types and the 4-of-N
// rotating picker function used by the SIMD adder scheduler.
package simd_sched_pkg;

  localparam int SIMD_LANES = 4;
  localparam int LANE_W     = 12;
  localparam int TAG_IDX_W  = 4;

  typedef logic [LANE_W-1:0] lane_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } lane_tag_t;

  typedef struct packed {
    lane_tag_t [SIMD_LANES-1:0] pick;
    logic [2:0]                 cnt;
    logic [TAG_IDX_W-1:0]       last;
  } pick4_t;

  // Scan from ptr modulo n; the k-th eligible hit lands in lane k.
  function automatic pick4_t rr_pick4(
    input logic [15:0]          elig,
    input logic [TAG_IDX_W-1:0] ptr,
    input int                   n
  );
    pick4_t r;
    int     k;
    int     idx;
    r = '0;
    k = 0;
    for (int s = 0; s < 16; s++) begin
      idx = (int'(ptr) + s) % n;
      if (s < n && k < SIMD_LANES && elig[idx[3:0]]) begin
        r.pick[k[1:0]].valid = 1'b1;
        r.pick[k[1:0]].idx   = idx[3:0];
        r.last               = idx[3:0];
        k++;
      end
    end
    r.cnt = k[2:0];
    return r;
  endfunction

endpackage

// File: rtl/rr_pick4_arb.sv
// rr_pick4_arb: combinational rotating picker, up to 4 of N_REQ.
// Ports: elig, ptr in; pick[4] {valid,idx}, cnt, last_idx out.
import simd_sched_pkg::*;

module rr_pick4_arb #(
  parameter int N_REQ = 8,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]             elig,
  input  logic [IDX_W-1:0]             ptr,
  output lane_tag_t [SIMD_LANES-1:0]   pick,
  output logic [2:0]                   cnt,
  output logic [IDX_W-1:0]             last_idx
);

  logic [15:0]          e16;
  logic [TAG_IDX_W-1:0] p4;
  pick4_t               r;

  always_comb begin
    e16 = '0;
    e16[N_REQ-1:0] = elig;
    p4 = '0;
    p4[IDX_W-1:0] = ptr;
    r = rr_pick4(e16, p4, N_REQ);
    pick = r.pick;
    cnt = r.cnt;
    last_idx = r.last[IDX_W-1:0];
  end

endmodule

// File: rtl/simd_add4_sched.sv
// simd_add4_sched: shares one 4x12b SIMD adder among N_REQ scalar requesters.
// Ports: ap_clk, ap_rst, req_valid/a/b, req_ready, simd_a/b, simd_ret,
// rsp_valid/data, busy; perf_issue_cnt/perf_lane_cnt with SIMD_SCHED_PERF_EN.
import simd_sched_pkg::*;

module simd_add4_sched #(
  parameter int N_REQ = 8,
  parameter int LAT   = 1,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*LANE_W-1:0]    req_a,
  input  logic [N_REQ*LANE_W-1:0]    req_b,
  output logic [N_REQ-1:0]           req_ready,
  output logic [SIMD_LANES*LANE_W-1:0] simd_a,
  output logic [SIMD_LANES*LANE_W-1:0] simd_b,
  input  logic [SIMD_LANES*LANE_W-1:0] simd_ret,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [N_REQ*LANE_W-1:0]    rsp_data,
  output logic                       busy
`ifdef SIMD_SCHED_PERF_EN
  ,
  output logic [31:0]                perf_issue_cnt,
  output logic [31:0]                perf_lane_cnt
`endif
);

  logic [N_REQ-1:0]            outstanding;
  logic [N_REQ-1:0]            elig;
  logic [IDX_W-1:0]            prio_ptr;
  lane_tag_t [SIMD_LANES-1:0]  pick;
  logic [2:0]                  pick_cnt;
  logic [IDX_W-1:0]            last_idx;
  logic [SIMD_LANES*LANE_W-1:0] lane_a;
  logic [SIMD_LANES*LANE_W-1:0] lane_b;
  logic [N_REQ-1:0]            rsp_v_nxt;
  logic [N_REQ*LANE_W-1:0]     rsp_d_nxt;

  // tag_q[0] rides with simd_a/b; tag_q[LAT] lines up with simd_ret.
  lane_tag_t [SIMD_LANES-1:0]  tag_q [LAT+1];

  assign elig = req_valid & ~outstanding;
  assign busy = |outstanding;

  rr_pick4_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .elig     (elig),
    .ptr      (prio_ptr),
    .pick     (pick),
    .cnt      (pick_cnt),
    .last_idx (last_idx)
  );

  always_comb begin
    req_ready = '0;
    lane_a = '0;
    lane_b = '0;
    for (int k = 0; k < SIMD_LANES; k++) begin
      if (pick[k].valid) begin
        req_ready[pick[k].idx[IDX_W-1:0]] = 1'b1;
        lane_a[k*LANE_W +: LANE_W] =
          req_a[pick[k].idx[IDX_W-1:0]*LANE_W +: LANE_W];
        lane_b[k*LANE_W +: LANE_W] =
          req_b[pick[k].idx[IDX_W-1:0]*LANE_W +: LANE_W];
      end
    end
  end

  always_comb begin
    rsp_v_nxt = '0;
    rsp_d_nxt = '0;
    for (int k = 0; k < SIMD_LANES; k++) begin
      if (tag_q[LAT][k].valid) begin
        rsp_v_nxt[tag_q[LAT][k].idx[IDX_W-1:0]] = 1'b1;
        rsp_d_nxt[tag_q[LAT][k].idx[IDX_W-1:0]*LANE_W +: LANE_W] =
          lane_t'(simd_ret[k*LANE_W +: LANE_W]);
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      simd_a <= '0;
      simd_b <= '0;
      prio_ptr <= '0;
      outstanding <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      for (int s = 0; s <= LAT; s++) tag_q[s] <= '0;
    end else begin
      simd_a <= lane_a;
      simd_b <= lane_b;
      tag_q[0] <= pick;
      for (int s = 1; s <= LAT; s++) tag_q[s] <= tag_q[s-1];
      if (pick[0].valid)
        prio_ptr <= (last_idx == IDX_W'(N_REQ-1)) ? '0 : last_idx + 1'b1;
      // Clear lands at the end of the response cycle, so regrant is next cycle.
      outstanding <= (outstanding & ~rsp_valid) | req_ready;
      rsp_valid <= rsp_v_nxt;
      rsp_data <= rsp_d_nxt;
    end
  end

`ifdef SIMD_SCHED_PERF_EN
  logic [32:0] lane_sum;
  assign lane_sum = {1'b0, perf_lane_cnt} + 33'(pick_cnt);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      perf_issue_cnt <= '0;
      perf_lane_cnt <= '0;
    end else begin
      if (pick[0].valid && perf_issue_cnt != '1)
        perf_issue_cnt <= perf_issue_cnt + 1'b1;
      perf_lane_cnt <= lane_sum[32] ? '1 : lane_sum[31:0];
    end
  end
`endif

endmodule
